// File: rtl/rx_deser_lanes.sv
// Serial receive path: comma-aligned word deserialiser with lock tracking that
// drops comma/idle symbols and deals data words round-robin across LANES outputs.
module rx_deser_lanes #(
  parameter int               WIDTH         = 8,
  parameter int               LANES         = 4,
  parameter logic [WIDTH-1:0] COMMA         = 8'hBC,
  parameter logic [WIDTH-1:0] IDLE          = 8'h7C,
  parameter int               LOCK_COUNT    = 4,
  parameter int               COMMA_TIMEOUT = 16
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  input  logic                    data_in,
  output logic [LANES*WIDTH-1:0]  data_out,
  output logic [LANES-1:0]        valid_out,
  output logic                    word_strobe,
  output logic                    active,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] lane_ptr
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);
  localparam int TO_W  = $clog2(COMMA_TIMEOUT + 1);

  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-2:0] sr_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LCK_W-1:0] comma_cnt_q, comma_cnt_d, comma_inc;
  logic [TO_W-1:0]  since_q, since_d, since_inc;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_next;
  logic             active_q, active_d;
  logic             strobe_q, strobe_d;
  logic [LANES-1:0] valid_q, valid_d;
  logic             wr_en;
  logic [WIDTH-1:0] lane_q [LANES];

  logic [WIDTH-1:0] cand;
  logic             word_done, is_comma, is_idle;

  assign cand      = {sr_q, data_in};
  assign word_done = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign is_comma  = (cand == COMMA);
  assign is_idle   = (cand == IDLE);
  assign comma_inc = comma_cnt_q + 1'b1;
  assign since_inc = since_q + 1'b1;
  assign ptr_next  = (ptr_q == PTR_W'(LANES - 1)) ? '0 : ptr_q + 1'b1;

  // NOTE: every output of this block is given a default first so no path
  // through the case statement leaves a value unassigned (which infers a latch).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = word_done ? '0 : bit_cnt_q + 1'b1;
    comma_cnt_d = comma_cnt_q;
    since_d     = since_q;
    ptr_d       = ptr_q;
    active_d    = active_q;
    strobe_d    = 1'b0;
    wr_en       = 1'b0;
    valid_d     = '0;

    unique case (state_q)
      SEARCH: begin
        // Any bit position may hold the comma; finding it sets word alignment.
        if (is_comma) begin
          bit_cnt_d   = '0;
          comma_cnt_d = LCK_W'(1);
          if (LOCK_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
            ptr_d    = '0;
            since_d  = '0;
          end else begin
            state_d = LOCKING;
          end
        end
      end
      LOCKING: begin
        if (word_done) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == LCK_W'(LOCK_COUNT)) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
              ptr_d    = '0;
              since_d  = '0;
            end
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (word_done) begin
          strobe_d = 1'b1;
          if (is_comma) begin
            ptr_d   = '0;
            since_d = '0;
          end else begin
            if (!is_idle) begin
              wr_en            = 1'b1;
              valid_d[ptr_q]   = 1'b1;
              ptr_d            = ptr_next;
            end
            since_d = since_inc;
            // The word that reaches the timeout is still delivered above.
            if (since_inc == TO_W'(COMMA_TIMEOUT)) begin
              state_d     = SEARCH;
              active_d    = 1'b0;
              comma_cnt_d = '0;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      since_q     <= '0;
      ptr_q       <= '0;
      active_q    <= 1'b0;
      strobe_q    <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= cand[WIDTH-2:0];
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      since_q     <= since_d;
      ptr_q       <= ptr_d;
      active_q    <= active_d;
      strobe_q    <= strobe_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: the lane registers are architecturally visible outputs that must read
  // zero after reset, so they are reset rather than left as uninitialised storage.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_en && (ptr_q == PTR_W'(k))) lane_q[k] <= cand;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign data_out[k*WIDTH +: WIDTH] = lane_q[k];
  end

  assign valid_out   = valid_q;
  assign word_strobe = strobe_q;
  assign active      = active_q;
  assign lane_ptr    = ptr_q;

endmodule

// File: tb/tb_rx_deser_lanes.sv
// Self-checking bench for rx_deser_lanes: a scoreboard of expected (lane, word)
// pairs is filled as data is serialised and drained on every valid_out pulse.
module tb_rx_deser_lanes;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b0;
  logic        data_in = 1'b0;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic        word_strobe;
  logic        active;
  logic [1:0]  lane_ptr;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   valid_cnt  = 0;
  int   exp_ptr    = 0;

  rx_deser_lanes dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .word_strobe(word_strobe),
    .active     (active),
    .lane_ptr   (lane_ptr)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: sampled 1 time unit after each active edge.
  always @(posedge clk_32f) begin
    #1;
    if (word_strobe) strobe_cnt++;
    if (valid_out != 4'b0) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_valid", {28'b0, valid_out}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("valid_lane", {28'b0, valid_out}, 32'(1 << e.lane));
        check("lane_data", {24'b0, data_out[e.lane*8 +: 8]}, {24'b0, e.data});
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #2;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Data word while locked: the bench tracks the expected lane itself.
  task automatic send_data(input logic [7:0] w);
    exp_t x;
    x.lane = exp_ptr;
    x.data = w;
    sb.push_back(x);
    exp_ptr = (exp_ptr + 1) % 4;
    send_word(w);
  endtask

  task automatic send_comma_active();
    exp_ptr = 0;
    send_word(8'hBC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with toggling serial input.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_32f);
      data_in = ~data_in;
    end
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", {28'b0, valid_out}, 32'h0);
    check("rst_strobe", {31'b0, word_strobe}, 32'h0);
    check("rst_active", {31'b0, active}, 32'h0);
    check("rst_lane_ptr", {30'b0, lane_ptr}, 32'h0);
    @(negedge clk_32f);
    reset = 1'b1;

    // Garbage bits, then four commas to lock.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    strobe_cnt = 0;
    for (int i = 0; i < 3; i++) send_word(8'hBC);
    check("lock_not_yet", {31'b0, active}, 32'h0);
    send_word(8'hBC);
    check("lock_active", {31'b0, active}, 32'h1);
    check("lock_strobes", strobe_cnt, 32'd3);
    check("lock_ptr", {30'b0, lane_ptr}, 32'h0);
    exp_ptr = 0;

    // Round-robin distribution with wrap.
    send_data(8'h11); send_data(8'h22); send_data(8'h33);
    send_data(8'h44); send_data(8'h55);
    check("rr_lane0", {24'b0, data_out[7:0]},   32'h55);
    check("rr_lane1", {24'b0, data_out[15:8]},  32'h22);
    check("rr_lane2", {24'b0, data_out[23:16]}, 32'h33);
    check("rr_lane3", {24'b0, data_out[31:24]}, 32'h44);
    check("rr_ptr", {30'b0, lane_ptr}, 32'h1);

    // Idle and comma dropped; comma restarts the lane pointer.
    send_comma_active();
    valid_cnt = 0;
    send_data(8'h11);
    send_word(8'h7C);
    send_data(8'h22);
    send_comma_active();
    send_data(8'h33);
    check("mix_valid_cnt", valid_cnt, 32'd3);
    check("mix_lane0", {24'b0, data_out[7:0]},  32'h33);
    check("mix_lane1", {24'b0, data_out[15:8]}, 32'h22);
    check("mix_ptr", {30'b0, lane_ptr}, 32'h1);

    // Comma timeout: 16 non-comma words drop lock on the 16th.
    send_comma_active();
    for (int i = 0; i < 15; i++) send_word(8'h7C);
    check("to_still_active", {31'b0, active}, 32'h1);
    send_word(8'h7C);
    check("to_lost", {31'b0, active}, 32'h0);
    for (int i = 0; i < 4; i++) send_word(8'hBC);
    check("relock", {31'b0, active}, 32'h1);
    exp_ptr = 0;

    // Mid-data reset clears outputs immediately.
    send_data(8'hA1);
    send_data(8'hB2);
    check("pre_rst_valid", {28'b0, valid_out}, 32'h2);
    reset = 1'b0;
    #1;
    check("midrst_valid", {28'b0, valid_out}, 32'h0);
    check("midrst_ptr", {30'b0, lane_ptr}, 32'h0);
    check("midrst_active", {31'b0, active}, 32'h0);
    check("midrst_data", data_out, 32'h0);
    @(negedge clk_32f);
    reset = 1'b1;

    // Non-comma during LOCKING falls back to SEARCH and restarts the count.
    strobe_cnt = 0;
    send_word(8'hBC); send_word(8'hBC); send_word(8'h00);
    check("lk_fail_active", {31'b0, active}, 32'h0);
    check("lk_fail_strobes", strobe_cnt, 32'd2);
    for (int i = 0; i < 3; i++) send_word(8'hBC);
    check("lk_restart_3", {31'b0, active}, 32'h0);
    send_word(8'hBC);
    check("lk_restart_4", {31'b0, active}, 32'h1);

    repeat (2) @(posedge clk_32f);
    #2;
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
